// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file write path: default widths,
// arbiter state encoding and requester encoding.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int NUM_REGS_DEF   = 8;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    RQ_ALU = 1'b0,
    RQ_MEM = 1'b1
  } req_e;

  // One-hot grant vector for a requester, bit index equals the requester code.
  function automatic logic [1:0] req_onehot(input req_e r);
    logic [1:0] v;
    if (r == RQ_MEM) begin
      v = 2'b10;
    end else begin
      v = 2'b01;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone eligible requester wins outright, a tie
// goes to the priority pointer, and the pointer then moves to the loser.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] elig_i,
  input  logic       prio_i,
  output logic [1:0] grant_o,
  output logic       prio_next_o
);

  // Grant selection and pointer update.
  always_comb begin
    grant_o     = 2'b00;
    prio_next_o = prio_i;
    case (elig_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = req_onehot(req_e'(prio_i));
      default: grant_o = 2'b00;
    endcase
    if (grant_o[0]) begin
      prio_next_o = RQ_MEM;
    end else if (grant_o[1]) begin
      prio_next_o = RQ_ALU;
    end else begin
      prio_next_o = prio_i;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the ALU and load-path writes onto the single register-file write
// port, and runs a sequential clear of every register on request.
module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ALU_REQ,
  input  logic [ADDR_WIDTH-1:0] ALU_REG,
  input  logic [DATA_WIDTH-1:0] ALU_DATA,
  output logic                  ALU_ACK,
  input  logic                  MEM_REQ,
  input  logic [ADDR_WIDTH-1:0] MEM_REG,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  output logic                  MEM_ACK,
  input  logic                  CLEAR_REQ,
  output logic                  CLEAR_BUSY,
  output logic                  WRITEENABLE,
  output logic [ADDR_WIDTH-1:0] WRITEREG,
  output logic [DATA_WIDTH-1:0] WRITEDATA
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aack_q, aack_d;
  logic                  mack_q, mack_d;
  logic                  busy_q, busy_d;

  logic [1:0]            elig_s;
  logic [1:0]            grant_s;
  logic                  prio_next_s;

  // A requester still seeing its ACK this cycle must not be granted again.
  assign elig_s = {MEM_REQ & ~mack_q, ALU_REQ & ~aack_q};

  rr_arb2 u_rr (
    .elig_i      (elig_s),
    .prio_i      (prio_q),
    .grant_o     (grant_s),
    .prio_next_o (prio_next_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    aack_d  = 1'b0;
    mack_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (CLEAR_REQ) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_ZERO;
        end else if (grant_s[0]) begin
          we_d    = 1'b1;
          wreg_d  = ALU_REG;
          wdata_d = ALU_DATA;
          aack_d  = 1'b1;
          prio_d  = prio_next_s;
        end else if (grant_s[1]) begin
          we_d    = 1'b1;
          wreg_d  = MEM_REG;
          wdata_d = MEM_DATA;
          mack_d  = 1'b1;
          prio_d  = prio_next_s;
        end else begin
          prio_d  = prio_q;
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        wreg_d  = cnt_q;
        wdata_d = DATA_ZERO;
        busy_d  = 1'b1;
        // Leaving on the last write lets held requests arbitrate at the edge
        // that closes that write cycle.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_ARB;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_ARB;
      prio_q  <= RQ_ALU;
      cnt_q   <= CNT_ZERO;
      we_q    <= 1'b0;
      wreg_q  <= CNT_ZERO;
      wdata_q <= DATA_ZERO;
      aack_q  <= 1'b0;
      mack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      aack_q  <= aack_d;
      mack_q  <= mack_d;
      busy_q  <= busy_d;
    end
  end

  assign WRITEENABLE = we_q;
  assign WRITEREG    = wreg_q;
  assign WRITEDATA   = wdata_q;
  assign ALU_ACK     = aack_q;
  assign MEM_ACK     = mack_q;
  assign CLEAR_BUSY  = busy_q;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, register data width; ADDR_WIDTH, default 3, register index width; NUM_REGS, default 8, register count.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports ALU_REQ (in, 1), ALU_REG (in, ADDR_WIDTH) and ALU_DATA (in, DATA_WIDTH): ALU write request, target register and data.
REQ-005 SHALL have port ALU_ACK, out, 1, one-cycle pulse when the ALU write is issued.
REQ-006 SHALL have ports MEM_REQ (in, 1), MEM_REG (in, ADDR_WIDTH) and MEM_DATA (in, DATA_WIDTH): load-path write request, target register and data.
REQ-007 SHALL have port MEM_ACK, out, 1, one-cycle pulse when the MEM write is issued.
REQ-008 SHALL have port CLEAR_REQ, input, 1, request to zero all registers.
REQ-009 SHALL have port CLEAR_BUSY, output, 1, high while the clear sequence runs.
REQ-010 SHALL have ports WRITEENABLE (out, 1), WRITEREG (out, ADDR_WIDTH) and WRITEDATA (out, DATA_WIDTH), driving the register-file write port.

Function
REQ-011 SHALL register all outputs, so a request sampled at edge N appears as WRITEENABLE, WRITEREG, WRITEDATA and the matching ACK during cycle N+1 (latency 1).
REQ-012 SHALL hold each requester's REQ/REG/DATA stable until its ACK is seen; a requester whose ACK is high in the current cycle is ineligible for that cycle (no double grant).
REQ-013 SHALL implement states ARB and CLEAR; ARB is the reset state.
REQ-014 SHALL grant, in ARB with exactly one eligible requester, that requester.
REQ-015 SHALL grant, in ARB with both requesters eligible, the requester selected by the priority pointer PRIO.
REQ-016 SHALL update PRIO after every grant to point at the non-granted requester.
REQ-017 SHALL drive, in ARB with no eligible request and no CLEAR_REQ, WRITEENABLE=0 and both ACKs 0 next cycle, leaving WRITEREG and WRITEDATA unchanged.
REQ-018 SHALL, on CLEAR_REQ=1 in ARB, enter CLEAR and reset the counter CNT to 0; CLEAR_REQ takes precedence over simultaneous ALU/MEM requests, which are not ACKed.
REQ-019 SHALL, in CLEAR, issue one write per cycle with WRITEREG=CNT and WRITEDATA=0, incrementing CNT from 0 to NUM_REGS-1.
REQ-020 SHALL return to ARB after the write of NUM_REGS-1, making a full clear exactly NUM_REGS consecutive WRITEENABLE cycles.
REQ-021 SHALL hold CLEAR_BUSY=1 from the cycle of the first clear write through the cycle of the last, and 0 otherwise.
REQ-022 SHALL ignore CLEAR_REQ while in CLEAR.
REQ-023 SHALL issue no ACK in CLEAR; pending requests stay held and arbitrate in ARB on the edge that ends CLEAR's last write cycle.
REQ-024 SHALL apply no special handling when ALU_REG equals MEM_REG under contention: writes issue in grant order, and the later write wins.

Reset
REQ-025 SHALL, when RESET=1 at a rising edge, set state ARB, PRIO=ALU, CNT=0, WRITEENABLE=0, WRITEREG=0, WRITEDATA=0, ALU_ACK=0, MEM_ACK=0 and CLEAR_BUSY=0.
REQ-026 SHALL abort any clear in progress on RESET, leaving already-zeroed registers as written.
REQ-027 SHALL ignore requests while RESET=1.

Structure
REQ-028 SHALL take DATA_WIDTH, ADDR_WIDTH, NUM_REGS defaults, the state encoding (ARB, CLEAR) and the requester encoding (ALU=0, MEM=1) from shared package cpu_pkg.
REQ-029 SHALL place two-way round-robin grant logic (eligible vectors and PRIO in, grant out, PRIO update) in sub-module rr_arb2.

Verification
REQ-030 Bench SHALL cover: single ALU request, ALU_REG=2 and ALU_DATA=95 held at edge N -> cycle N+1 WRITEENABLE=1, WRITEREG=2, WRITEDATA=95, ALU_ACK=1; cycle N+2 WRITEENABLE=0.
REQ-031 Bench SHALL cover: ALU (reg 1, data 28) and MEM (reg 4, data 6) both held from reset -> ALU written first, then MEM next cycle, MEM_ACK=1 only in the second write cycle.
REQ-032 Bench SHALL cover: both requesters held continuously with new data each ACK -> grants alternate ALU, MEM, ALU, MEM with no idle cycle and no double grant.
REQ-033 Bench SHALL cover: CLEAR_REQ pulse with ALU_REQ held (reg 7, data 50) -> 8 writes of 0 to regs 0..7 with CLEAR_BUSY=1 for exactly those 8 cycles, then the ALU write of 50 to reg 7 with ALU_ACK.
REQ-034 Bench SHALL cover: RESET=1 on the third clear write cycle -> all outputs 0 next cycle, state ARB, and a subsequent MEM request granted normally.
REQ-035 Bench SHALL cover: same-register contention, ALU (reg 3, data 15) and MEM (reg 3, data 9) with PRIO=MEM -> MEM write then ALU write, reg 3 reads back 15.
